// File: rtl/fifo_pix_stream_rd.sv
// Reader side of the sync pixel FIFO: drains it into a valid/ready stream with SOF/EOL framing.
// Optional saturating underrun counter port when FIFO_PIX_RD_UNDERRUN_CNT_EN is defined.
module fifo_pix_stream_rd #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned H_ACTIVE   = 1920,
  parameter int unsigned V_ACTIVE   = 1080,
  parameter int unsigned CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  frame_done,
  output logic                  busy
`ifdef FIFO_PIX_RD_UNDERRUN_CNT_EN
  ,
  output logic [15:0]           underrun_cnt
`endif
);

  localparam int unsigned DEPTH = RD_LATENCY + 1;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned ISS_W = 2 * CNT_W;

  localparam logic [ISS_W-1:0] FRAME_TOTAL = ISS_W'(H_ACTIVE * V_ACTIVE);
  localparam logic [2:0]       DEPTH_C     = 3'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST    = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_ACTIVE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] skid_q [2**PTR_W];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;
  logic [RD_LATENCY-1:0] inflight_q, inflight_d;
  logic [2:0]            inflight_cnt;
  logic [CNT_W-1:0]      h_cnt_q, v_cnt_q;
  logic [ISS_W-1:0]      issue_cnt_q;
  logic                  frame_done_q;
  logic                  push, pop, h_wrap, xfer_last, space_ok;

  assign push    = inflight_q[RD_LATENCY-1];
  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid & m_ready;

  assign h_wrap    = pop & (h_cnt_q == H_LAST);
  assign xfer_last = h_wrap & (v_cnt_q == V_LAST);

  always_comb begin
    inflight_cnt = 3'd0;
    for (int i = 0; i < int'(RD_LATENCY); i++) begin
      inflight_cnt = inflight_cnt + {2'b00, inflight_q[i]};
    end
  end

  // Reads already in flight reserve a slot; a same-cycle pop frees one.
  assign space_ok = (({1'b0, occ_q} + inflight_cnt) < (DEPTH_C + {2'b00, pop}));

  always_comb begin
    inflight_d    = inflight_q << 1;
    inflight_d[0] = fifo_rd_en;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      skid_q[wr_ptr_q] <= fifo_rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= 2'd0;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      issue_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 2'd1;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
      if (pop) begin
        if (h_wrap) begin
          h_cnt_q <= '0;
          v_cnt_q <= xfer_last ? '0 : v_cnt_q + CNT_W'(1);
        end else begin
          h_cnt_q <= h_cnt_q + CNT_W'(1);
        end
      end
      frame_done_q <= xfer_last;
      if (frame_done_q) begin
        issue_cnt_q <= '0;
      end else if (fifo_rd_en) begin
        issue_cnt_q <= issue_cnt_q + ISS_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (enable) state_d = StRun;
      // Nothing issued yet (or frame just closed): stopping needs no drain.
      StRun: begin
        if (!enable) begin
          state_d = (frame_done_q || (issue_cnt_q == '0)) ? StIdle : StStop;
        end
      end
      StStop: begin
        if (frame_done_q) begin
          state_d = StIdle;
        end else if (enable) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy       = (state_q != StIdle);
    fifo_rd_en = busy & ~fifo_rd_empty & space_ok & (issue_cnt_q < FRAME_TOTAL);
    m_data     = m_valid ? skid_q[rd_ptr_q] : '0;
    m_sof      = m_valid & (h_cnt_q == '0) & (v_cnt_q == '0);
    m_eol      = m_valid & (h_cnt_q == H_LAST);
    frame_done = frame_done_q;
  end

`ifdef FIFO_PIX_RD_UNDERRUN_CNT_EN
  logic [15:0] underrun_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_q <= 16'h0000;
    end else if (busy && ((h_cnt_q != '0) || (v_cnt_q != '0)) && m_ready && !m_valid &&
                 fifo_rd_empty && (underrun_q != 16'hFFFF)) begin
      underrun_q <= underrun_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_fifo_pix_stream_rd.sv
// Directed bench for fifo_pix_stream_rd: H_ACTIVE=4, V_ACTIVE=2, one DUT per read latency.
module tb_fifo_pix_stream_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en1, en2, m_ready, fifo_clr;
  logic        rd_en1, rd_en2, empty1, empty2;
  logic [23:0] rd_data1, rd_data2;
  logic        v1, v2, sof1, sof2, eol1, eol2, fd1, fd2, busy1, busy2;
  logic [23:0] data1, data2;
`ifdef FIFO_PIX_RD_UNDERRUN_CNT_EN
  logic [15:0] urc1, urc2;
`endif

  fifo_pix_stream_rd #(
    .DATA_WIDTH(24), .RD_LATENCY(1), .H_ACTIVE(4), .V_ACTIVE(2), .CNT_W(12)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(en1), .fifo_rd_en(rd_en1), .fifo_rd_data(rd_data1),
    .fifo_rd_empty(empty1), .m_valid(v1), .m_ready(m_ready), .m_data(data1), .m_sof(sof1),
    .m_eol(eol1), .frame_done(fd1), .busy(busy1)
`ifdef FIFO_PIX_RD_UNDERRUN_CNT_EN
    , .underrun_cnt(urc1)
`endif
  );

  fifo_pix_stream_rd #(
    .DATA_WIDTH(24), .RD_LATENCY(2), .H_ACTIVE(4), .V_ACTIVE(2), .CNT_W(12)
  ) dut2 (
    .clk(clk), .rst(rst), .enable(en2), .fifo_rd_en(rd_en2), .fifo_rd_data(rd_data2),
    .fifo_rd_empty(empty2), .m_valid(v2), .m_ready(m_ready), .m_data(data2), .m_sof(sof2),
    .m_eol(eol2), .frame_done(fd2), .busy(busy2)
`ifdef FIFO_PIX_RD_UNDERRUN_CNT_EN
    , .underrun_cnt(urc2)
`endif
  );

  // FIFO models: latency 1 for dut1, latency 2 (output register) for dut2.
  logic [23:0] mem1 [256];
  logic [23:0] mem2 [256];
  int wr1 = 0, rd1 = 0, wr2 = 0, rd2 = 0;
  logic [23:0] d1, d2a, d2b;

  assign empty1   = (rd1 == wr1);
  assign empty2   = (rd2 == wr2);
  assign rd_data1 = d1;
  assign rd_data2 = d2b;

  always @(posedge clk) begin
    if (fifo_clr) begin
      rd1 <= wr1;
      rd2 <= wr2;
    end else begin
      if (rd_en1 && (rd1 != wr1)) begin
        d1  <= mem1[rd1 % 256];
        rd1 <= rd1 + 1;
      end
      if (rd_en2 && (rd2 != wr2)) begin
        d2a <= mem2[rd2 % 256];
        rd2 <= rd2 + 1;
      end
    end
    d2b <= d2a;
  end

  bit use2 = 1'b0;
  logic        obs_v, obs_sof, obs_eol, obs_fd, obs_busy, obs_rd, obs_empty;
  logic [23:0] obs_data;
  assign obs_v     = use2 ? v2 : v1;
  assign obs_data  = use2 ? data2 : data1;
  assign obs_sof   = use2 ? sof2 : sof1;
  assign obs_eol   = use2 ? eol2 : eol1;
  assign obs_fd    = use2 ? fd2 : fd1;
  assign obs_busy  = use2 ? busy2 : busy1;
  assign obs_rd    = use2 ? rd_en2 : rd_en1;
  assign obs_empty = use2 ? empty2 : empty1;

  int compared = 0;
  int mismatched = 0;

  logic [23:0] g_data [$];
  bit          g_sof [$];
  bit          g_eol [$];
  int          g_cyc [$];
  int          fd_cyc [$];
  int cyc, first_rd, first_v, max_out, stall_bad, empty_rd, last_rd;
  bit busy_low;

  task automatic clear_log();
    g_data.delete(); g_sof.delete(); g_eol.delete(); g_cyc.delete(); fd_cyc.delete();
    first_rd = -1; first_v = -1; max_out = 0; stall_bad = 0; empty_rd = 0; last_rd = -1;
    busy_low = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; fifo_clr = 1'b1; en1 = 1'b0; en2 = 1'b0; m_ready = 1'b0; use2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; fifo_clr = 1'b0;
    clear_log();
    cyc = 0;
  endtask

  task automatic load(input bit which, input logic [23:0] first, input bit down, input int n);
    for (int i = 0; i < n; i++) begin
      if (which) begin
        mem2[wr2 % 256] = down ? first - 24'(i) : first + 24'(i);
        wr2++;
      end else begin
        mem1[wr1 % 256] = down ? first - 24'(i) : first + 24'(i);
        wr1++;
      end
    end
  endtask

  // mode 0: ready high, 1: ready toggles 1010..., drop_after/stop_after count transfers.
  task automatic run(input int n, input int mode, input int drop_after, input int stop_after);
    int issued, xfers, depth;
    logic prev_stall;
    logic [23:0] prev_data;
    issued = 0; xfers = 0; prev_stall = 1'b0; prev_data = '0;
    depth = use2 ? 3 : 2;
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      #1;
      m_ready = (mode == 0) ? 1'b1 : ((c % 2) == 0);
      #1;
      cyc++;
      if (prev_stall && (!obs_v || (obs_data !== prev_data))) stall_bad++;
      if (obs_rd && obs_empty) empty_rd++;
      if (obs_rd) begin
        issued++;
        last_rd = cyc;
        if (first_rd < 0) first_rd = cyc;
      end
      if (obs_v && (first_v < 0)) first_v = cyc;
      if (!obs_busy) busy_low = 1'b1;
      if (obs_fd) fd_cyc.push_back(cyc);
      prev_stall = obs_v && !m_ready;
      prev_data  = obs_data;
      if (obs_v && m_ready) begin
        g_data.push_back(obs_data); g_sof.push_back(obs_sof); g_eol.push_back(obs_eol);
        g_cyc.push_back(cyc);
        xfers++;
        if (xfers == drop_after) begin
          if (use2) en2 = 1'b0;
          else en1 = 1'b0;
        end
        if ((issued - xfers) > max_out) max_out = issued - xfers;
        if (xfers == stop_after) return;
      end
      if ((issued - xfers) > max_out) max_out = issued - xfers;
      if (max_out > depth) stall_bad += 1000;
    end
  endtask

  task automatic test_reset();
    do_reset();
    compared++; if (v1 !== 1'b0) begin mismatched++; $display("FAIL rst_valid got %b want 0", v1); end
    compared++; if (data1 !== 24'h0) begin mismatched++; $display("FAIL rst_data got %h want 0", data1); end
    compared++; if (sof1 !== 1'b0) begin mismatched++; $display("FAIL rst_sof got %b want 0", sof1); end
    compared++; if (eol1 !== 1'b0) begin mismatched++; $display("FAIL rst_eol got %b want 0", eol1); end
    compared++; if (fd1 !== 1'b0) begin mismatched++; $display("FAIL rst_fd got %b want 0", fd1); end
    compared++; if (busy1 !== 1'b0) begin mismatched++; $display("FAIL rst_busy got %b want 0", busy1); end
    compared++; if (rd_en1 !== 1'b0) begin mismatched++; $display("FAIL rst_rd_en got %b want 0", rd_en1); end
    compared++; if (busy2 !== 1'b0) begin mismatched++; $display("FAIL rst_busy2 got %b want 0", busy2); end
  endtask

  task automatic test_stream();
    do_reset();
    load(1'b0, 24'hFFFFFF, 1'b1, 8);
    en1 = 1'b1;
    run(30, 0, -1, -1);
    compared++; if (g_data.size() != 8) begin mismatched++; $display("FAIL t1_count got %0d want 8", g_data.size()); end
    for (int k = 0; k < g_data.size(); k++) begin
      compared++;
      if (g_data[k] !== 24'hFFFFFF - 24'(k)) begin
        mismatched++; $display("FAIL t1_data[%0d] got %h want %h", k, g_data[k], 24'hFFFFFF - 24'(k));
      end
      compared++; if (g_sof[k] !== (k == 0)) begin mismatched++; $display("FAIL t1_sof[%0d] got %b", k, g_sof[k]); end
      compared++; if (g_eol[k] !== ((k % 4) == 3)) begin mismatched++; $display("FAIL t1_eol[%0d] got %b", k, g_eol[k]); end
      if (k > 0) begin
        compared++;
        if (g_cyc[k] !== g_cyc[k-1] + 1) begin
          mismatched++; $display("FAIL t1_rate[%0d] got cyc %0d want %0d", k, g_cyc[k], g_cyc[k-1] + 1);
        end
      end
    end
    compared++; if (first_v - first_rd !== 2) begin mismatched++; $display("FAIL t1_latency got %0d want 2", first_v - first_rd); end
    compared++; if (fd_cyc.size() != 1) begin mismatched++; $display("FAIL t1_fd_count got %0d want 1", fd_cyc.size()); end
    if ((fd_cyc.size() > 0) && (g_cyc.size() == 8)) begin
      compared++;
      if (fd_cyc[0] !== g_cyc[7] + 1) begin
        mismatched++; $display("FAIL t1_fd_cyc got %0d want %0d", fd_cyc[0], g_cyc[7] + 1);
      end
    end
    compared++; if (busy_low !== 1'b0) begin mismatched++; $display("FAIL t1_busy got low want high"); end
  endtask

  task automatic test_backpressure();
    do_reset();
    load(1'b0, 24'h000200, 1'b0, 8);
    en1 = 1'b1;
    run(40, 1, -1, -1);
    compared++; if (g_data.size() != 8) begin mismatched++; $display("FAIL t2_count got %0d want 8", g_data.size()); end
    for (int k = 0; k < g_data.size(); k++) begin
      compared++;
      if (g_data[k] !== 24'h000200 + 24'(k)) begin
        mismatched++; $display("FAIL t2_data[%0d] got %h want %h", k, g_data[k], 24'h000200 + 24'(k));
      end
      compared++; if (g_eol[k] !== ((k % 4) == 3)) begin mismatched++; $display("FAIL t2_eol[%0d] got %b", k, g_eol[k]); end
    end
    compared++; if (stall_bad !== 0) begin mismatched++; $display("FAIL t2_stall got %0d bad want 0", stall_bad); end
    compared++; if (max_out > 2) begin mismatched++; $display("FAIL t2_occupancy got %0d want <=2", max_out); end
    compared++; if (empty_rd !== 0) begin mismatched++; $display("FAIL t2_rd_empty got %0d want 0", empty_rd); end
    compared++; if (fd_cyc.size() != 1) begin mismatched++; $display("FAIL t2_fd_count got %0d want 1", fd_cyc.size()); end
  endtask

  task automatic test_latency2();
    do_reset();
    use2 = 1'b1;
    load(1'b1, 24'hFFFFFF, 1'b1, 8);
    en2 = 1'b1;
    run(30, 0, -1, -1);
    compared++; if (g_data.size() != 8) begin mismatched++; $display("FAIL t3_count got %0d want 8", g_data.size()); end
    for (int k = 0; k < g_data.size(); k++) begin
      compared++;
      if (g_data[k] !== 24'hFFFFFF - 24'(k)) begin
        mismatched++; $display("FAIL t3_data[%0d] got %h want %h", k, g_data[k], 24'hFFFFFF - 24'(k));
      end
      compared++; if (g_sof[k] !== (k == 0)) begin mismatched++; $display("FAIL t3_sof[%0d] got %b", k, g_sof[k]); end
      compared++; if (g_eol[k] !== ((k % 4) == 3)) begin mismatched++; $display("FAIL t3_eol[%0d] got %b", k, g_eol[k]); end
      if (k > 0) begin
        compared++;
        if (g_cyc[k] !== g_cyc[k-1] + 1) begin
          mismatched++; $display("FAIL t3_rate[%0d] got cyc %0d want %0d", k, g_cyc[k], g_cyc[k-1] + 1);
        end
      end
    end
    compared++; if (first_v - first_rd !== 3) begin mismatched++; $display("FAIL t3_latency got %0d want 3", first_v - first_rd); end
    compared++; if (max_out > 3) begin mismatched++; $display("FAIL t3_occupancy got %0d want <=3", max_out); end
    compared++; if (fd_cyc.size() != 1) begin mismatched++; $display("FAIL t3_fd_count got %0d want 1", fd_cyc.size()); end
    use2 = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    load(1'b0, 24'h000400, 1'b0, 3);
    en1 = 1'b1;
    run(10, 0, -1, -1);
    load(1'b0, 24'h000403, 1'b0, 5);
    run(25, 0, -1, -1);
    compared++; if (g_data.size() != 8) begin mismatched++; $display("FAIL t4_count got %0d want 8", g_data.size()); end
    for (int k = 0; k < g_data.size(); k++) begin
      compared++;
      if (g_data[k] !== 24'h000400 + 24'(k)) begin
        mismatched++; $display("FAIL t4_data[%0d] got %h want %h", k, g_data[k], 24'h000400 + 24'(k));
      end
      compared++; if (g_sof[k] !== (k == 0)) begin mismatched++; $display("FAIL t4_sof[%0d] got %b", k, g_sof[k]); end
      compared++; if (g_eol[k] !== ((k % 4) == 3)) begin mismatched++; $display("FAIL t4_eol[%0d] got %b", k, g_eol[k]); end
    end
    if (g_cyc.size() >= 4) begin
      compared++;
      if (g_cyc[3] - g_cyc[2] <= 1) begin
        mismatched++; $display("FAIL t4_gap got %0d cycles want >1", g_cyc[3] - g_cyc[2]);
      end
    end
    compared++; if (fd_cyc.size() != 1) begin mismatched++; $display("FAIL t4_fd_count got %0d want 1", fd_cyc.size()); end
    if ((fd_cyc.size() > 0) && (g_cyc.size() == 8)) begin
      compared++;
      if (fd_cyc[0] !== g_cyc[7] + 1) begin
        mismatched++; $display("FAIL t4_fd_cyc got %0d want %0d", fd_cyc[0], g_cyc[7] + 1);
      end
    end
    compared++; if (empty_rd !== 0) begin mismatched++; $display("FAIL t4_rd_empty got %0d want 0", empty_rd); end
  endtask

  task automatic test_stop();
    do_reset();
    load(1'b0, 24'h000500, 1'b0, 16);
    en1 = 1'b1;
    run(40, 0, 2, -1);
    compared++; if (g_data.size() != 8) begin mismatched++; $display("FAIL t5_count got %0d want 8", g_data.size()); end
    for (int k = 0; k < g_data.size(); k++) begin
      compared++;
      if (g_data[k] !== 24'h000500 + 24'(k)) begin
        mismatched++; $display("FAIL t5_data[%0d] got %h want %h", k, g_data[k], 24'h000500 + 24'(k));
      end
    end
    compared++; if (fd_cyc.size() != 1) begin mismatched++; $display("FAIL t5_fd_count got %0d want 1", fd_cyc.size()); end
    compared++; if (wr1 - rd1 !== 8) begin mismatched++; $display("FAIL t5_fifo_left got %0d want 8", wr1 - rd1); end
    compared++; if (busy1 !== 1'b0) begin mismatched++; $display("FAIL t5_busy got %b want 0", busy1); end
    compared++; if (rd_en1 !== 1'b0) begin mismatched++; $display("FAIL t5_rd_en got %b want 0", rd_en1); end
    if (fd_cyc.size() > 0) begin
      compared++;
      if (last_rd >= fd_cyc[0]) begin
        mismatched++; $display("FAIL t5_late_rd got cyc %0d want < %0d", last_rd, fd_cyc[0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [23:0] exp_head;
    do_reset();
    load(1'b0, 24'h000600, 1'b0, 16);
    en1 = 1'b1;
    run(40, 0, -1, 5);
    compared++; if (g_data.size() != 5) begin mismatched++; $display("FAIL t6_pre_count got %0d want 5", g_data.size()); end
    @(posedge clk);
    #1;
    rst = 1'b1; m_ready = 1'b0;
    @(posedge clk);
    #1;
    compared++; if (v1 !== 1'b0) begin mismatched++; $display("FAIL t6_valid got %b want 0", v1); end
    compared++; if (data1 !== 24'h0) begin mismatched++; $display("FAIL t6_data got %h want 0", data1); end
    compared++; if (sof1 !== 1'b0) begin mismatched++; $display("FAIL t6_sof got %b want 0", sof1); end
    compared++; if (eol1 !== 1'b0) begin mismatched++; $display("FAIL t6_eol got %b want 0", eol1); end
    compared++; if (busy1 !== 1'b0) begin mismatched++; $display("FAIL t6_busy got %b want 0", busy1); end
    compared++; if (rd_en1 !== 1'b0) begin mismatched++; $display("FAIL t6_rd_en got %b want 0", rd_en1); end
    rst = 1'b0;
    exp_head = mem1[rd1 % 256];
    clear_log();
    run(30, 0, -1, 1);
    compared++; if (g_data.size() != 1) begin mismatched++; $display("FAIL t6_post_count got %0d want 1", g_data.size()); end
    if (g_data.size() > 0) begin
      compared++; if (g_sof[0] !== 1'b1) begin mismatched++; $display("FAIL t6_new_sof got %b want 1", g_sof[0]); end
      compared++;
      if (g_data[0] !== exp_head) begin
        mismatched++; $display("FAIL t6_new_data got %h want %h", g_data[0], exp_head);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency2();
    test_underflow();
    test_stop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
